// File: rtl/rv32i_mem_arbiter_pkg.sv
// Shared types and constants for the RV32I instruction/data memory arbiter.
package rv32i_mem_arbiter_pkg;

   // Arbiter FSM: one memory transaction outstanding at a time
   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      D_REQ = 3'd1,
      D_RSP = 3'd2,
      F_REQ = 3'd3,
      F_RSP = 3'd4
   } mem_arb_state_t;

   // Canonical RV32I NOP (addi x0, x0, 0), inserted by the controlpath on stalls
   localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

   // Byte enables for a full-word instruction fetch
   localparam logic [3:0] BE_WORD = 4'hF;

endpackage

// File: rtl/rv32i_sat_counter.sv
// Saturating up-counter: counts enabled cycles and sticks at all-ones.
module rv32i_sat_counter #(
   parameter int WIDTH = 32
) (
   input  logic             clk_i,
   input  logic             resetn_i,
   input  logic             en_i,
   output logic [WIDTH-1:0] count_o
);

   localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

   // Increment on enable until the counter reaches its maximum value
   always_ff @(posedge clk_i or negedge resetn_i) begin
      if (!resetn_i) begin
         count_o <= '0;
      end else if (en_i && (count_o != {WIDTH{1'b1}})) begin
         count_o <= count_o + ONE;
      end
   end

endmodule

// File: rtl/rv32i_mem_arbiter.sv
// Arbitrates a single-port memory between instruction fetch and MEM-stage
// data accesses (data first) and produces the pipeline-wide stall.
module rv32i_mem_arbiter
   import rv32i_mem_arbiter_pkg::*;
#(
   parameter int CNT_W = 32
) (
   input  logic             clk_i,
   input  logic             resetn_i,
   // instruction fetch port
   input  logic             if_req_i,
   input  logic [31:0]      if_addr_i,
   output logic [31:0]      if_rdata_o,
   output logic             if_valid_o,
   input  logic             flush_i,
   // MEM-stage data port
   input  logic             d_re_i,
   input  logic             d_we_i,
   input  logic [31:0]      d_addr_i,
   input  logic [31:0]      d_wdata_i,
   input  logic [3:0]       d_be_i,
   output logic [31:0]      d_rdata_o,
   output logic             d_valid_o,
   // unified memory
   output logic             mem_req_o,
   output logic             mem_we_o,
   output logic [31:0]      mem_addr_o,
   output logic [31:0]      mem_wdata_o,
   output logic [3:0]       mem_be_o,
   input  logic             mem_gnt_i,
   input  logic             mem_rvalid_i,
   input  logic [31:0]      mem_rdata_i,
   // pipeline control
   output logic             stall_o,
   output logic [CNT_W-1:0] stall_cnt_o
);

   mem_arb_state_t state_r;

   logic        d_done_r;
   logic        f_done_r;
   logic        discard_r;
   logic [31:0] d_buf_r;
   logic [31:0] f_buf_r;

   // request fields held while waiting for a grant
   logic        req_we_r;
   logic [31:0] req_addr_r;
   logic [31:0] req_wdata_r;
   logic [3:0]  req_be_r;

   logic d_req;
   logic d_pend;
   logic f_pend;
   logic d_bypass;
   logic f_bypass;

   assign d_req    = d_re_i | d_we_i;
   assign d_pend   = d_req & ~d_done_r;
   assign f_pend   = if_req_i & ~f_done_r & ~flush_i;
   assign d_bypass = (state_r == D_RSP) & mem_rvalid_i;
   assign f_bypass = (state_r == F_RSP) & mem_rvalid_i;

   // Response data is forwarded in the rvalid cycle, then served from the buffer
   assign d_valid_o  = d_done_r | d_bypass;
   assign d_rdata_o  = d_bypass ? mem_rdata_i : d_buf_r;
   assign if_valid_o = (f_done_r | f_bypass) & ~discard_r;
   assign if_rdata_o = f_bypass ? mem_rdata_i : f_buf_r;

   // A flushed fetch no longer holds the pipeline; the new target is fetched next
   assign stall_o = (d_req & ~d_valid_o) | (if_req_i & ~if_valid_o & ~flush_i);

   // Drive the memory request: live inputs in IDLE, captured fields while waiting
   always_comb begin
      mem_req_o   = 1'b0;
      mem_we_o    = 1'b0;
      mem_addr_o  = 32'h0;
      mem_wdata_o = 32'h0;
      mem_be_o    = 4'h0;
      case (state_r)
         IDLE: begin
            if (d_pend) begin
               mem_req_o   = 1'b1;
               mem_we_o    = d_we_i;
               mem_addr_o  = d_addr_i;
               mem_wdata_o = d_wdata_i;
               mem_be_o    = d_be_i;
            end else if (f_pend) begin
               mem_req_o   = 1'b1;
               mem_we_o    = 1'b0;
               mem_addr_o  = if_addr_i;
               mem_be_o    = BE_WORD;
            end
         end
         D_REQ, F_REQ: begin
            // a flush withdraws a fetch that has not been granted yet
            mem_req_o   = (state_r == D_REQ) ? 1'b1 : ~flush_i;
            mem_we_o    = req_we_r;
            mem_addr_o  = req_addr_r;
            mem_wdata_o = req_wdata_r;
            mem_be_o    = req_be_r;
         end
         default: ;
      endcase
   end

   // FSM: issue, wait for grant, wait for response
   always_ff @(posedge clk_i or negedge resetn_i) begin
      if (!resetn_i) begin
         state_r <= IDLE;
      end else begin
         case (state_r)
            IDLE: begin
               if (d_pend) begin
                  state_r <= mem_gnt_i ? D_RSP : D_REQ;
               end else if (f_pend) begin
                  state_r <= mem_gnt_i ? F_RSP : F_REQ;
               end
            end
            D_REQ: if (mem_gnt_i) state_r <= D_RSP;
            F_REQ: begin
               if (flush_i) begin
                  state_r <= IDLE;
               end else if (mem_gnt_i) begin
                  state_r <= F_RSP;
               end
            end
            D_RSP: if (mem_rvalid_i) state_r <= IDLE;
            F_RSP: if (mem_rvalid_i) state_r <= IDLE;
            default: state_r <= IDLE;
         endcase
      end
   end

   // Completion and discard flags; completions are forgotten once the pipeline advances
   always_ff @(posedge clk_i or negedge resetn_i) begin
      if (!resetn_i) begin
         d_done_r  <= 1'b0;
         f_done_r  <= 1'b0;
         discard_r <= 1'b0;
      end else begin
         if (!stall_o) begin
            d_done_r <= 1'b0;
         end else if (d_bypass) begin
            d_done_r <= 1'b1;
         end

         if (!stall_o || flush_i) begin
            f_done_r <= 1'b0;
         end else if (f_bypass && !discard_r) begin
            f_done_r <= 1'b1;
         end

         if (state_r == F_RSP) begin
            if (mem_rvalid_i) begin
               discard_r <= 1'b0;
            end else if (flush_i) begin
               discard_r <= 1'b1;
            end
         end
      end
   end

   // Response buffers hold load data / instruction until the pipeline takes them
   always_ff @(posedge clk_i or negedge resetn_i) begin
      if (!resetn_i) begin
         d_buf_r <= 32'h0;
         f_buf_r <= 32'h0;
      end else begin
         if (d_bypass) d_buf_r <= mem_rdata_i;
         if (f_bypass) f_buf_r <= mem_rdata_i;
      end
   end

   // Capture the IDLE-cycle request so it stays stable until granted
   always_ff @(posedge clk_i) begin
      if (state_r == IDLE) begin
         req_we_r    <= mem_we_o;
         req_addr_r  <= mem_addr_o;
         req_wdata_r <= mem_wdata_o;
         req_be_r    <= mem_be_o;
      end
   end

   rv32i_sat_counter #(
      .WIDTH (CNT_W)
   ) u_stall_cnt (
      .clk_i    (clk_i),
      .resetn_i (resetn_i),
      .en_i     (stall_o),
      .count_o  (stall_cnt_o)
   );

endmodule

// File: tb/tb_rv32i_mem_arbiter.sv
// Self-checking bench for rv32i_mem_arbiter with a behavioural memory model.
module tb_rv32i_mem_arbiter;
   import rv32i_mem_arbiter_pkg::*;

   localparam int CNT_W = 4;

   logic             clk_i;
   logic             resetn_i;
   logic             if_req_i;
   logic [31:0]      if_addr_i;
   logic [31:0]      if_rdata_o;
   logic             if_valid_o;
   logic             flush_i;
   logic             d_re_i;
   logic             d_we_i;
   logic [31:0]      d_addr_i;
   logic [31:0]      d_wdata_i;
   logic [3:0]       d_be_i;
   logic [31:0]      d_rdata_o;
   logic             d_valid_o;
   logic             mem_req_o;
   logic             mem_we_o;
   logic [31:0]      mem_addr_o;
   logic [31:0]      mem_wdata_o;
   logic [3:0]       mem_be_o;
   logic             mem_gnt_i;
   logic             mem_rvalid_i;
   logic [31:0]      mem_rdata_i;
   logic             stall_o;
   logic [CNT_W-1:0] stall_cnt_o;

   rv32i_mem_arbiter #(.CNT_W(CNT_W)) dut (
      .clk_i        (clk_i),
      .resetn_i     (resetn_i),
      .if_req_i     (if_req_i),
      .if_addr_i    (if_addr_i),
      .if_rdata_o   (if_rdata_o),
      .if_valid_o   (if_valid_o),
      .flush_i      (flush_i),
      .d_re_i       (d_re_i),
      .d_we_i       (d_we_i),
      .d_addr_i     (d_addr_i),
      .d_wdata_i    (d_wdata_i),
      .d_be_i       (d_be_i),
      .d_rdata_o    (d_rdata_o),
      .d_valid_o    (d_valid_o),
      .mem_req_o    (mem_req_o),
      .mem_we_o     (mem_we_o),
      .mem_addr_o   (mem_addr_o),
      .mem_wdata_o  (mem_wdata_o),
      .mem_be_o     (mem_be_o),
      .mem_gnt_i    (mem_gnt_i),
      .mem_rvalid_i (mem_rvalid_i),
      .mem_rdata_i  (mem_rdata_i),
      .stall_o      (stall_o),
      .stall_cnt_o  (stall_cnt_o)
   );

   initial begin
      clk_i = 1'b0;
      forever #5 clk_i = ~clk_i;
   end

   // memory contents
   function automatic logic [31:0] mem_fn(input logic [31:0] a);
      case (a)
         32'h0000_0100: mem_fn = 32'h0050_0093;
         32'h0000_0104: mem_fn = 32'h0010_0113;
         32'h0000_0200: mem_fn = 32'hDEAD_BEEF;
         default:       mem_fn = a ^ 32'hA5A5_0000;
      endcase
   endfunction

   // memory model: grant after gnt_delay waiting cycles, rvalid rsp_delay cycles after grant
   int          gnt_delay = 0;
   int          rsp_delay = 1;
   bit          gnt_block = 1'b0;
   int          wait_cnt  = 0;
   int          rsp_cnt   = 0;
   logic [31:0] rsp_addr  = 32'h0;

   assign mem_gnt_i    = mem_req_o && !gnt_block && (wait_cnt >= gnt_delay);
   assign mem_rvalid_i = (rsp_cnt == 1);
   assign mem_rdata_i  = mem_rvalid_i ? mem_fn(rsp_addr) : 32'h0;

   // Memory model timing state
   always @(posedge clk_i) begin
      if (mem_req_o && !mem_gnt_i) wait_cnt <= wait_cnt + 1;
      else                         wait_cnt <= 0;
      if (mem_gnt_i) begin
         rsp_cnt  <= rsp_delay;
         rsp_addr <= mem_addr_o;
      end else if (rsp_cnt > 0) begin
         rsp_cnt <= rsp_cnt - 1;
      end
   end

   // scoreboard
   typedef struct {
      logic        we;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [3:0]  be;
   } req_t;

   req_t        exp_req_q[$];
   logic [31:0] exp_d_q[$];
   logic [31:0] exp_f_q[$];
   bit          d_seen, f_seen;
   logic [31:0] d_hold, f_hold;

   int checks = 0;
   int errors = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %08h expected %08h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic push_data(input bit we, input logic [31:0] a, input logic [31:0] wd,
                            input logic [3:0] be);
      req_t r;
      r.we = we; r.addr = a; r.wdata = wd; r.be = be;
      exp_req_q.push_back(r);
      exp_d_q.push_back(mem_fn(a));
   endtask

   task automatic push_fetch_req(input logic [31:0] a);
      req_t r;
      r.we = 1'b0; r.addr = a; r.wdata = 32'h0; r.be = 4'hF;
      exp_req_q.push_back(r);
   endtask

   task automatic cmp_req(input string tag, input req_t r);
      chk({tag, "_addr"}, mem_addr_o, r.addr);
      chk({tag, "_we"}, {31'h0, mem_we_o}, {31'h0, r.we});
      chk({tag, "_be"}, {28'h0, mem_be_o}, {28'h0, r.be});
      if (r.we) chk({tag, "_wdata"}, mem_wdata_o, r.wdata);
   endtask

   // one sampled cycle: request order/stability and response values
   task automatic mon_cycle();
      req_t r;
      if (mem_req_o && mem_gnt_i) begin
         if (exp_req_q.size() == 0) chk("unexpected_grant", mem_addr_o, 32'hFFFF_FFFF);
         else begin
            r = exp_req_q.pop_front();
            cmp_req("grant", r);
         end
      end else if (mem_req_o && exp_req_q.size() != 0) begin
         cmp_req("wait", exp_req_q[0]);
      end
      if (d_valid_o) begin
         if (!d_seen) begin
            d_seen = 1'b1;
            if (exp_d_q.size() == 0) d_hold = 32'hBAD0_BAD0;
            else d_hold = exp_d_q.pop_front();
         end
         chk("d_rdata", d_rdata_o, d_hold);
      end else d_seen = 1'b0;
      if (if_valid_o) begin
         if (!f_seen) begin
            f_seen = 1'b1;
            if (exp_f_q.size() == 0) f_hold = 32'hBAD1_BAD1;
            else f_hold = exp_f_q.pop_front();
         end
         chk("if_rdata", if_rdata_o, f_hold);
      end else f_seen = 1'b0;
   endtask

   task automatic idle_inputs();
      if_req_i  = 1'b0; if_addr_i = 32'h0; flush_i = 1'b0;
      d_re_i    = 1'b0; d_we_i    = 1'b0;
      d_addr_i  = 32'h0; d_wdata_i = 32'h0; d_be_i = 4'h0;
   endtask

   task automatic do_reset();
      @(negedge clk_i);
      resetn_i = 1'b0;
      idle_inputs();
      gnt_block = 1'b0; gnt_delay = 0; rsp_delay = 1;
      exp_req_q.delete(); exp_d_q.delete(); exp_f_q.delete();
      d_seen = 1'b0; f_seen = 1'b0;
      repeat (4) @(negedge clk_i);
      resetn_i = 1'b1;
      #1;
      chk("rst_mem_req", {31'h0, mem_req_o}, 32'h0);
      chk("rst_stall_cnt", {28'h0, stall_cnt_o}, 32'h0);
      chk("rst_d_valid", {31'h0, d_valid_o}, 32'h0);
      chk("rst_if_valid", {31'h0, if_valid_o}, 32'h0);
      chk("rst_stall", {31'h0, stall_o}, 32'h0);
      chk("rst_state", 32'(dut.state_r), 32'(IDLE));
   endtask

   // caller is at a negedge with inputs applied; returns at the first non-stall cycle
   task automatic wait_release(input string tag, output int stalls);
      bit done;
      stalls = 0;
      done   = 1'b0;
      for (int c = 0; c < 60 && !done; c++) begin
         #1;
         mon_cycle();
         if (stall_o) stalls++;
         else done = 1'b1;
         if (!done) @(negedge clk_i);
      end
      if (!done) chk({tag, "_timeout"}, 32'h1, 32'h0);
   endtask

   // pipeline advances: drop requests and confirm completions are forgotten
   task automatic advance(input string tag);
      @(negedge clk_i);
      idle_inputs();
      #1;
      mon_cycle();
      chk({tag, "_d_valid_clr"}, {31'h0, d_valid_o}, 32'h0);
      chk({tag, "_if_valid_clr"}, {31'h0, if_valid_o}, 32'h0);
      chk({tag, "_q_empty"}, exp_req_q.size() + exp_d_q.size() + exp_f_q.size(), 32'h0);
   endtask

   typedef struct {
      bit          d_re;
      bit          d_we;
      logic [31:0] d_addr;
      logic [31:0] d_wdata;
      logic [3:0]  d_be;
      bit          f_req;
      logic [31:0] f_addr;
      int          gd;
      int          rd;
      int          exp_stalls;
   } vec_t;

   vec_t vecs[8];

   initial begin
      int stalls;
      string tag;

      resetn_i = 1'b0;
      idle_inputs();

      //          re    we    d_addr        d_wdata       be    f     f_addr       gd rd stalls
      vecs[0] = '{1'b0, 1'b0, 32'h0,        32'h0,        4'h0, 1'b1, 32'h100,     0, 1, 1};
      vecs[1] = '{1'b1, 1'b0, 32'h200,      32'h0,        4'hF, 1'b0, 32'h0,       0, 1, 1};
      vecs[2] = '{1'b1, 1'b0, 32'h200,      32'h0,        4'hF, 1'b1, 32'h104,     0, 1, 3};
      vecs[3] = '{1'b0, 1'b1, 32'h208,      32'h1234_5678,4'h3, 1'b0, 32'h0,       2, 1, 3};
      vecs[4] = '{1'b0, 1'b1, 32'h20C,      32'hCAFE_F00D,4'hC, 1'b1, 32'h108,     1, 1, 5};
      vecs[5] = '{1'b1, 1'b0, 32'h210,      32'h0,        4'hF, 1'b1, 32'h10C,     0, 2, 5};
      vecs[6] = '{1'b0, 1'b0, 32'h0,        32'h0,        4'h0, 1'b0, 32'h0,       0, 1, 0};
      vecs[7] = '{1'b0, 1'b0, 32'h0,        32'h0,        4'h0, 1'b1, 32'h110,     1, 2, 3};

      for (int i = 0; i < 8; i++) begin
         tag = $sformatf("v%0d", i);
         do_reset();
         gnt_delay = vecs[i].gd;
         rsp_delay = vecs[i].rd;
         @(negedge clk_i);
         d_re_i = vecs[i].d_re; d_we_i = vecs[i].d_we;
         d_addr_i = vecs[i].d_addr; d_wdata_i = vecs[i].d_wdata; d_be_i = vecs[i].d_be;
         if_req_i = vecs[i].f_req; if_addr_i = vecs[i].f_addr;
         if (vecs[i].d_re || vecs[i].d_we)
            push_data(vecs[i].d_we, vecs[i].d_addr, vecs[i].d_wdata, vecs[i].d_be);
         if (vecs[i].f_req) begin
            push_fetch_req(vecs[i].f_addr);
            exp_f_q.push_back(mem_fn(vecs[i].f_addr));
         end
         wait_release(tag, stalls);
         chk({tag, "_stalls"}, stalls, vecs[i].exp_stalls);
         chk({tag, "_stall_cnt"}, {28'h0, stall_cnt_o}, vecs[i].exp_stalls);
         advance(tag);
      end

      // flush while the fetch response is outstanding
      do_reset();
      rsp_delay = 3;
      @(negedge clk_i);
      if_req_i = 1'b1; if_addr_i = 32'h100;
      push_fetch_req(32'h100);
      push_fetch_req(32'h104);
      exp_f_q.push_back(mem_fn(32'h104));
      #1;
      mon_cycle();
      chk("fl_first_stall", {31'h0, stall_o}, 32'h1);
      @(negedge clk_i);
      flush_i = 1'b1;
      #1;
      mon_cycle();
      chk("fl_state_frsp", 32'(dut.state_r), 32'(F_RSP));
      chk("fl_flush_nostall", {31'h0, stall_o}, 32'h0);
      @(negedge clk_i);
      flush_i = 1'b0; if_addr_i = 32'h104;
      wait_release("fl", stalls);
      chk("fl_stalls", stalls, 5);
      chk("fl_stall_cnt", {28'h0, stall_cnt_o}, 6);
      advance("fl");

      // reset while a load response is outstanding, then a stray rvalid
      do_reset();
      rsp_delay = 3;
      @(negedge clk_i);
      d_re_i = 1'b1; d_addr_i = 32'h200; d_be_i = 4'hF;
      push_data(1'b0, 32'h200, 32'h0, 4'hF);
      exp_d_q.delete();
      #1;
      mon_cycle();
      @(negedge clk_i);
      chk("rr_state_drsp", 32'(dut.state_r), 32'(D_RSP));
      resetn_i = 1'b0;
      idle_inputs();
      #1;
      chk("rr_mem_req", {31'h0, mem_req_o}, 32'h0);
      chk("rr_state", 32'(dut.state_r), 32'(IDLE));
      chk("rr_stall_cnt", {28'h0, stall_cnt_o}, 32'h0);
      @(negedge clk_i);
      resetn_i = 1'b1;
      for (int c = 0; c < 4; c++) begin
         #1;
         mon_cycle();
         chk("rr_d_valid", {31'h0, d_valid_o}, 32'h0);
         chk("rr_if_valid", {31'h0, if_valid_o}, 32'h0);
         chk("rr_idle", 32'(dut.state_r), 32'(IDLE));
         @(negedge clk_i);
      end

      // stall counter saturation with the grant withheld
      do_reset();
      gnt_block = 1'b1;
      @(negedge clk_i);
      d_re_i = 1'b1; d_addr_i = 32'h300; d_be_i = 4'hF;
      push_data(1'b0, 32'h300, 32'h0, 4'hF);
      for (int c = 0; c < (1 << CNT_W) + 5; c++) begin
         #1;
         mon_cycle();
         chk("sat_stall", {31'h0, stall_o}, 32'h1);
         chk("sat_cnt", {28'h0, stall_cnt_o}, (c < 15) ? c : 15);
         @(negedge clk_i);
      end
      #1;
      chk("sat_cnt_max", {28'h0, stall_cnt_o}, 32'hF);
      gnt_block = 1'b0;
      wait_release("sat", stalls);
      chk("sat_cnt_hold", {28'h0, stall_cnt_o}, 32'hF);
      advance("sat");

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
